pipelined_adder: RTL

//   Parametrised, pipelined add/subtract unit with carry-in/carry-out and a

---
 rtl/adder_pkg.sv | 18 +
 rtl/pipelined_adder_stage.sv | 61 ++++++
 rtl/pipelined_adder.sv | 85 ++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the pipelined add/subtract unit.
package adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } adder_op_e;

    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Legal slicing: every stage resolves a full, non-empty CHUNK of the word.
    function automatic bit chunking_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One registered CHUNK-bit slice of the pipelined adder. Operand A and the partial
// sum share one word: bits below IDX*CHUNK are finished sum, bits above are still A.
module pipelined_adder_stage
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             valid_in,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] word_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             valid_out,
    output logic             carry_out,
    output logic             msb_carry_out,
    output logic [WIDTH-1:0] word_out,
    output logic [WIDTH-1:0] b_out
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             c_next;
    logic             msb_c_next;
    logic [WIDTH-1:0] word_next;
    logic [WIDTH-1:0] b_next;

    // B arrives already inverted for SUB and shifted so its live slice sits at bit 0.
    always_comb begin
        a_slice    = word_in[LO +: CHUNK];
        b_slice    = b_in[CHUNK-1:0];
        {c_next, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_in};
        msb_c_next = s_slice[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];
        word_next  = word_in;
        word_next[LO +: CHUNK] = s_slice;
        b_next     = b_in >> CHUNK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out     <= 1'b0;
            carry_out     <= 1'b0;
            msb_carry_out <= 1'b0;
            word_out      <= '0;
            b_out         <= '0;
        end else if (en) begin
            valid_out     <= valid_in;
            carry_out     <= c_next;
            msb_carry_out <= msb_c_next;
            word_out      <= word_next;
            b_out         <= b_next;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit operands resolved CHUNK bits per stage,
// streamed over valid/ready with one result per cycle and STAGES cycles of latency.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);

    if (!chunking_ok(WIDTH, CHUNK)) begin : g_bad_chunk
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Handshake: a beat moves on a rising edge when valid && ready on that side.
    // The whole pipeline advances together whenever the output slot is empty or
    // being drained, so in_ready never looks at in_valid and a stall freezes every
    // stage (bubbles included) in place.
    logic      adv;
    adder_op_e op;
    logic      cin_eff;
    logic [WIDTH-1:0] b_eff;

    logic             valid_pipe [STAGES+1];
    logic             carry_pipe [STAGES+1];
    logic [WIDTH-1:0] word_pipe  [STAGES+1];
    logic [WIDTH-1:0] b_pipe     [STAGES+1];
    logic             msb_pipe   [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // SUB is A + ~B + !borrow_in, so the same carry chain serves both operations.
    assign op      = adder_op_e'(in_sub);
    assign b_eff   = (op == OP_SUB) ? ~in_b : in_b;
    assign cin_eff = (op == OP_SUB) ? ~in_cin : in_cin;

    assign valid_pipe[0] = in_valid;
    assign carry_pipe[0] = cin_eff;
    assign word_pipe[0]  = in_a;
    assign b_pipe[0]     = b_eff;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipelined_adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk           (clk),
            .rst           (rst),
            .en            (adv),
            .valid_in      (valid_pipe[k]),
            .carry_in      (carry_pipe[k]),
            .word_in       (word_pipe[k]),
            .b_in          (b_pipe[k]),
            .valid_out     (valid_pipe[k+1]),
            .carry_out     (carry_pipe[k+1]),
            .msb_carry_out (msb_pipe[k]),
            .word_out      (word_pipe[k+1]),
            .b_out         (b_pipe[k+1])
        );
    end

    // Overflow: carry into the MSB disagrees with carry out of it.
    assign out_valid = valid_pipe[STAGES];
    assign out_sum   = word_pipe[STAGES];
    assign out_cout  = carry_pipe[STAGES];
    assign out_ovf   = msb_pipe[STAGES-1] ^ carry_pipe[STAGES];

endmodule
